microp_led_ctrl: RTL and testbench



---
 rtl/microp_led_ctrl.sv | 110 +++++++++++
 tb/tb_microp_led_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/microp_led_ctrl.sv
// Avalon-MM LED/output-port controller: data register with atomic set/clear and a blink engine.
// Optional global PWM dimming (DUTY register at address 6) when LED_CTRL_PWM_EN is defined.
module microp_led_ctrl #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PRESCALE_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic                  wr;
    logic [WIDTH-1:0]      data_out;
    logic [WIDTH-1:0]      blink_mask;
    logic [PRESCALE_W-1:0] period;
    logic [PRESCALE_W-1:0] cnt;
    logic                  phase;
    logic                  pwm_on;
    logic                  unused_ok;

    assign wr        = chipselect & ~write_n;
    assign unused_ok = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                3'd0:    data_out <= writedata[WIDTH-1:0];
                3'd3:    data_out <= data_out | writedata[WIDTH-1:0];
                3'd4:    data_out <= data_out & ~writedata[WIDTH-1:0];
                default: data_out <= data_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask <= '0;
        end else if (wr && address == 3'd1) begin
            blink_mask <= writedata[WIDTH-1:0];
        end
    end

    // A PERIOD write restarts the countdown and wins over the same-cycle tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (wr && address == 3'd2) begin
            period <= writedata[PRESCALE_W-1:0];
            cnt    <= writedata[PRESCALE_W-1:0];
            phase  <= 1'b0;
        end else if (period == '0) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == '0) begin
            cnt   <= period;
            phase <= ~phase;
        end else begin
            cnt <= cnt - PRESCALE_W'(1);
        end
    end

`ifdef LED_CTRL_PWM_EN
    logic [7:0] duty;
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty    <= 8'hFF;
            pwm_cnt <= 8'h00;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (wr && address == 3'd6) begin
                duty <= writedata[7:0];
            end
        end
    end

    // 0xFF is forced fully on so the top duty setting has no dark slot.
    assign pwm_on = (duty == 8'hFF) | (pwm_cnt < duty);
`else
    assign pwm_on = 1'b1;
`endif

    assign out_port = (data_out ^ ({WIDTH{phase}} & blink_mask)) & {WIDTH{pwm_on}};

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[WIDTH-1:0]      = data_out;
            3'd1: readdata[WIDTH-1:0]      = blink_mask;
            3'd2: readdata[PRESCALE_W-1:0] = period;
            3'd5: readdata[1:0]            = {period != '0, phase};
`ifdef LED_CTRL_PWM_EN
            3'd6: readdata[7:0]            = duty;
`endif
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_microp_led_ctrl.sv
// Directed self-checking bench for microp_led_ctrl (WIDTH=8, RESET_VALUE=0, PRESCALE_W=24).
// Covers both builds: PWM checks follow LED_CTRL_PWM_EN.
module tb_microp_led_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    microp_led_ctrl #(
        .WIDTH(8),
        .RESET_VALUE(8'h00),
        .PRESCALE_W(24)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write lands on the next rising edge; returns 1ns after it.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_addr6;
    int on_cnt;
    int off_cnt;

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        #1;
        check("reset_out_port", {24'h0, out_port}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

`ifdef LED_CTRL_PWM_EN
        exp_addr6 = 32'h0000_00FF;
`else
        exp_addr6 = 32'h0;
`endif
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("reset_read_addr%0d", i), rd, (i == 6) ? exp_addr6 : 32'h0);
        end

        // DATA writes and upper-bit truncation
        bus_write(3'd0, 32'h0000_00A5);
        check("data_a5_out", {24'h0, out_port}, 32'h0000_00A5);
        bus_read(3'd0, rd);
        check("data_a5_read", rd, 32'h0000_00A5);
        bus_write(3'd0, 32'hFFFF_FF5A);
        check("data_5a_out", {24'h0, out_port}, 32'h0000_005A);
        bus_read(3'd0, rd);
        check("data_5a_read", rd, 32'h0000_005A);

        // Atomic set/clear
        bus_write(3'd0, 32'h0000_00A5);
        bus_write(3'd3, 32'h0000_000F);
        check("outset_out", {24'h0, out_port}, 32'h0000_00AF);
        bus_write(3'd4, 32'h0000_0003);
        check("outclear_out", {24'h0, out_port}, 32'h0000_00AC);
        bus_read(3'd3, rd);
        check("outset_read", rd, 32'h0);
        bus_read(3'd4, rd);
        check("outclear_read", rd, 32'h0);

        // Blink bit0 with PERIOD 3: phase flips on every 4th edge after the write
        bus_write(3'd1, 32'h0000_0001);
        check("mask_out_steady", {24'h0, out_port}, 32'h0000_00AC);
        bus_read(3'd1, rd);
        check("mask_read", rd, 32'h0000_0001);
        bus_write(3'd2, 32'h0000_0003);
        check("period_write_out", {24'h0, out_port}, 32'h0000_00AC);
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(((k / 4) % 2 == 1) ? 8'hAD : 8'hAC);
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("blink_cycle%0d", k), {24'h0, out_port}, {24'h0, exp_q.pop_front()});
        end
        bus_read(3'd5, rd);
        check("status_blinking", rd, 32'h0000_0003);
        bus_read(3'd2, rd);
        check("period_read", rd, 32'h0000_0003);

        // OUTSET landing on the same edge as a phase toggle
        bus_write(3'd2, 32'h0000_0003);
        repeat (3) @(posedge clk);
        bus_write(3'd3, 32'h0000_0010);
        check("outset_on_toggle_out", {24'h0, out_port}, 32'h0000_00BD);
        bus_read(3'd0, rd);
        check("outset_on_toggle_data", rd, 32'h0000_00BC);

        // Stopping the blink
        bus_write(3'd2, 32'h0);
        check("period0_out", {24'h0, out_port}, 32'h0000_00BC);
        bus_read(3'd5, rd);
        check("period0_status", rd, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("period0_steady", {24'h0, out_port}, 32'h0000_00BC);

        // Asynchronous reset mid-blink
        bus_write(3'd1, 32'h0000_00FF);
        bus_write(3'd2, 32'h0000_0001);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", {24'h0, out_port}, 32'h0);
        address = 3'd5;
        #1;
        check("async_reset_status", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef LED_CTRL_PWM_EN
        bus_write(3'd0, 32'h0000_00FF);
        bus_write(3'd6, 32'h0000_0040);
        bus_read(3'd6, rd);
        check("duty_read", rd, 32'h0000_0040);
        on_cnt = 0;
        off_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            if (out_port == 8'hFF) on_cnt++;
            if (out_port == 8'h00) off_cnt++;
        end
        check("duty40_on_cycles", 32'(on_cnt), 32'd64);
        check("duty40_off_cycles", 32'(off_cnt), 32'd192);
        bus_write(3'd6, 32'h0);
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            if (out_port != 8'h00) on_cnt++;
        end
        check("duty0_on_cycles", 32'(on_cnt), 32'd0);
        bus_write(3'd6, 32'h0000_00FF);
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            if (out_port == 8'hFF) on_cnt++;
        end
        check("dutyff_on_cycles", 32'(on_cnt), 32'd256);
`else
        bus_write(3'd6, 32'h0000_0040);
        bus_read(3'd6, rd);
        check("addr6_read", rd, 32'h0);
        bus_write(3'd0, 32'h0000_00FF);
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            if (out_port == 8'hFF) on_cnt++;
        end
        check("ungated_on_cycles", 32'(on_cnt), 32'd256);
`endif

        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd7, rd);
        check("reserved_read", rd, 32'h0);
        check("reserved_no_effect", {24'h0, out_port}, 32'h0000_00FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
